// File: rtl/sp_fifo_pkg.sv
// Shared widths and grant encoding for the single-port-RAM FIFO controller.
package sp_fifo_pkg;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LVL_W  = 8;

  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} grant_t;
endpackage

// File: rtl/sp_fifo_arb.sv
// One-RAM-op-per-cycle arbiter between FIFO push (write) and output-register refill (read).
// SP_FIFO_BYPASS_EN: empty FIFO with a free output slot loads push data straight into rd_data.
module sp_fifo_arb
  import sp_fifo_pkg::*;
#(
  parameter int CNT_W   = ADDR_W + 1,
  parameter int DEPTH_P = DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic             slot_free,
  input  logic [CNT_W-1:0] ram_cnt,
  output grant_t           gnt,
  output logic             byp,
  output logic             wr_ready
);

  logic last_rd_q, last_rd_d;
  logic rd_elig, rd_g, wr_g, not_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_rd_q <= 1'b0;
    else      last_rd_q <= last_rd_d;
  end

  always_comb begin
    not_full = (ram_cnt != CNT_W'(DEPTH_P));
    rd_elig  = (ram_cnt != '0) & slot_free;
`ifdef SP_FIFO_BYPASS_EN
    byp      = (ram_cnt == '0) & slot_free & wr_valid;
`else
    byp      = 1'b0;
`endif
    // On a tie, last_rd flips priority so reads and writes alternate.
    rd_g      = rd_elig & (!wr_valid | !last_rd_q);
    wr_g      = !rd_g & wr_valid & not_full & !byp;
    wr_ready  = not_full & !rd_g;
    last_rd_d = (rd_g | wr_g) ? rd_g : last_rd_q;
    gnt       = rd_g ? GNT_RD : (wr_g ? GNT_WR : GNT_NONE);
  end

endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM with a one-entry registered output.
// Optional SP_FIFO_BYPASS_EN (in sp_fifo_arb) gives 1-cycle latency on an empty FIFO.
module sp_ram_fifo_ctrl
  import sp_fifo_pkg::*;
#(
  parameter int DATA_W = sp_fifo_pkg::DATA_W,
  parameter int ADDR_W = sp_fifo_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic [LVL_W-1:0]  level,
  output logic              ram_enb,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int DEPTH_L = 1 << ADDR_W;
  localparam int CNT_W   = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  grant_t            gnt;
  logic              byp, slot_free;

  assign slot_free = !rd_valid_q | rd_ready;

  sp_fifo_arb #(.CNT_W(CNT_W), .DEPTH_P(DEPTH_L)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .slot_free (slot_free),
    .ram_cnt   (ram_cnt_q),
    .gnt       (gnt),
    .byp       (byp),
    .wr_ready  (wr_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    if (gnt == GNT_RD) begin
      rd_data_d  = ram_rdata;
      rd_valid_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + 1'b1;
      ram_cnt_d  = ram_cnt_q - 1'b1;
    end else if (byp) begin
      rd_data_d  = wr_data;
      rd_valid_d = 1'b1;
    end else if (rd_valid_q & rd_ready) begin
      rd_valid_d = 1'b0;
    end
    if (gnt == GNT_WR) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q + 1'b1;
    end
  end

  assign ram_enb   = (gnt == GNT_WR);
  assign ram_addr  = (gnt == GNT_WR) ? wr_ptr_q : rd_ptr_q;
  assign ram_wdata = wr_data;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign level     = LVL_W'(ram_cnt_q) + LVL_W'(rd_valid_q);

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Bench for sp_ram_fifo_ctrl with a behavioural 128x4 RAM behind it and a queue scoreboard.
module tb_sp_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_data = 4'h0;
  logic       wr_ready;
  logic       rd_valid;
  logic [3:0] rd_data;
  logic       rd_ready = 1'b0;
  logic [7:0] level;
  logic       ram_enb;
  logic [6:0] ram_addr;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sp_ram_fifo_ctrl dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .level(level),
    .ram_enb(ram_enb), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Single-port RAM: combinational read, write on rising edge.
  logic [3:0] mem [128];
  initial for (int i = 0; i < 128; i++) mem[i] = 4'h0;
  always @(posedge clk) if (ram_enb) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: accepted data queue, occupancy, expected next RAM write address.
  logic [3:0] sb_q[$];
  int         occ = 0;
  int         wexp = 0;
  int         pops = 0;
  bit         saw_wrap = 1'b0;
  int         prev_waddr = -1;

  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
      occ = 0;
      wexp = 0;
      prev_waddr = -1;
    end else begin
      chk("level", int'(level), occ);
      if (occ == 129) chk("full_wr_ready", int'(wr_ready), 0);
      if (ram_enb) begin
        chk("wr_addr", int'(ram_addr), wexp);
        if (prev_waddr == 127 && ram_addr == 7'd0) saw_wrap = 1'b1;
        prev_waddr = int'(ram_addr);
        wexp = (wexp + 1) % 128;
      end
      if (wr_valid && wr_ready) begin
        sb_q.push_back(wr_data);
        occ++;
      end
      if (rd_valid && rd_ready) begin
        pops++;
        if (sb_q.size() == 0) chk("pop_empty_model", 1, 0);
        else chk("rd_data", int'(rd_data), int'(sb_q.pop_front()));
        occ--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (level == 8'd0) break;
      step();
    end
    chk("drain_level", int'(level), 0);
    step();
    rd_ready = 1'b0;
  endtask

  initial begin
    int acc, sent, p0, stuck;
    bit byp_en;
`ifdef SP_FIFO_BYPASS_EN
    byp_en = 1'b1;
`else
    byp_en = 1'b0;
`endif
    // Reset state
    @(negedge clk);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ram_enb", int'(ram_enb), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    step();
    rst = 1'b1;

    // Test 1 / 6: single push latency
    wr_valid = 1'b1;
    wr_data = 4'hA;
    @(negedge clk);
    chk("t1_c0_enb", int'(ram_enb), byp_en ? 0 : 1);
    chk("t1_c0_addr", int'(ram_addr), 0);
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    if (byp_en) begin
      chk("t1_byp_rd_valid", int'(rd_valid), 1);
      chk("t1_byp_rd_data", int'(rd_data), 10);
      chk("t1_byp_enb", int'(ram_enb), 0);
    end else begin
      chk("t1_c1_enb", int'(ram_enb), 0);
      chk("t1_c1_addr", int'(ram_addr), 0);
      chk("t1_c1_rd_valid", int'(rd_valid), 0);
      step();
      @(negedge clk);
      chk("t1_c2_rd_valid", int'(rd_valid), 1);
      chk("t1_c2_rd_data", int'(rd_data), 10);
    end
    chk("t1_level", int'(level), 1);
    drain();

    // Test 2: fill with no pops
    acc = 0;
    wr_valid = 1'b1;
    for (int i = 0; i < 140; i++) begin
      wr_data = 4'($urandom);
      @(negedge clk);
      if (wr_ready) acc++;
      step();
    end
    @(negedge clk);
    chk("t2_accepted", acc, 129);
    chk("t2_level", int'(level), 129);
    chk("t2_rd_valid", int'(rd_valid), 1);
    stuck = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      if (wr_ready) stuck++;
    end
    chk("t2_wr_ready_held_low", stuck, 0);
    step();

    // Test 3: backlog with both sides active alternates RD, WR, ...
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 4'($urandom);
      @(negedge clk);
      chk("t3_alternate", int'(ram_enb), i % 2);
      step();
    end
    drain();

    // Test 4: random stream of 300 incrementing values
    sent = 0;
    p0 = pops;
    for (int n = 0; n < 6000; n++) begin
      if (sent >= 300 && level == 8'd0) break;
      wr_valid = (sent < 300) && ($urandom_range(9) < 7);
      wr_data = 4'(sent);
      rd_ready = $urandom_range(1) == 1;
      @(negedge clk);
      if (wr_valid && wr_ready) sent++;
      step();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    chk("t4_sent", sent, 300);
    chk("t4_popped", pops - p0, 300);
    chk("t4_addr_wrap_seen", int'(saw_wrap), 1);

    // Test 5: reset with content in flight
    acc = 0;
    wr_valid = 1'b1;
    for (int n = 0; n < 50 && acc < 5; n++) begin
      wr_data = 4'($urandom);
      @(negedge clk);
      if (wr_ready) acc++;
      step();
    end
    wr_valid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("t5_level_pre", int'(level), 5);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("t5_rd_valid", int'(rd_valid), 0);
    chk("t5_level", int'(level), 0);
    chk("t5_ram_addr", int'(ram_addr), 0);
    chk("t5_wr_ready", int'(wr_ready), 1);
    step();
    rst = 1'b1;
    wr_valid = 1'b1;
    wr_data = 4'h5;
    @(negedge clk);
    chk("t5_first_addr", int'(ram_addr), 0);
    chk("t5_first_enb", int'(ram_enb), byp_en ? 0 : 1);
    step();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
